regs_master: RTL and testbench
==============================

# regs_master

Register-bus initiator that drives the request side of the configuration register block: `req`, `addr`, `rd_wr`, `write_val`, with `read_val` and `ack` returning. A host or test controller issues one command at a time over a valid/ready command port and collects the result over a valid/ready response port. The block sits between that host and the register block and enforces single-outstanding, ack-terminated register transactions with an optional timeout.

## Interface

Parameters:
- `ADDR_SIZE_P`, default 4, register address width.
- `TIMEOUT_P`, default 16, number of cycles to wait for `ack` before aborting; must be 2..255.

Ports:
- Clocking: one clock `clk`; reset `reset_L` is asynchronous and active-low.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset_L`  in  1  asynchronous active-low reset.
- `cmd_valid`  in  1  host command valid.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_rd_wr`  in  1  0 = read, 1 = write.
- `cmd_addr`  in  ADDR_SIZE_P  register address.
- `cmd_wdata`  in  32  write data; ignored for reads.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  host accepts the response.
- `rsp_rdata`  out  32  read data; 0 for writes and errors.
- `rsp_err`  out  1  transaction aborted by timeout.
- `req`  out  1  register request.
- `addr`  out  ADDR_SIZE_P  register address.
- `rd_wr`  out  1  0 = read, 1 = write.
- `write_val`  out  32  write data.
- `read_val`  in  32  register read data; valid in the `ack` cycle.
- `ack`  in  1  register block completion, one-cycle pulse.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation

- FSM states: IDLE, REQ, RSP.
- IDLE:
  - `cmd_ready` = 1.
  - On `cmd_valid && cmd_ready`, register `cmd_addr`, `cmd_rd_wr` and `cmd_wdata` into `addr`, `rd_wr` and `write_val`, then go to REQ.
- REQ:
  - `req` = 1. `addr`, `rd_wr` and `write_val` are held stable.
  - `cmd_ready` = 0.
  - Wait counter increments every cycle.
- `ack` in REQ:
  - Go to RSP.
  - Capture `rsp_rdata` = `read_val` for a read, or 0 for a write.
  - `rsp_err` = 0.
- RSP:
  - `req` = 0 and `rsp_valid` = 1.
  - `rsp_rdata` and `rsp_err` are held until `rsp_ready`.
  - On `rsp_valid && rsp_ready`, go to IDLE.
- `ack` outside REQ is ignored and has no state change.
- Wait counter: 8 bits, cleared on entry to REQ.
- `addr`, `rd_wr` and `write_val` keep their last value after the transaction ends. They are not cleared.

## Timing

- Reset values:
  - State = IDLE.
  - `req`, `rsp_valid`, `rsp_err` and `busy` = 0.
  - `cmd_ready` = 1.
  - `addr`, `rd_wr`, `write_val` and `rsp_rdata` = 0.
  - Counter = 0.
- Command accepted at edge T:
  - `req` is high from cycle T+1.
  - The earliest `ack` is sampled in cycle T+1.
  - `rsp_valid` is high in cycle T+2.
- `req` drops in the cycle after `ack` is sampled. Consecutive requests are therefore always separated by at least 2 cycles of `req` = 0, because they pass through RSP and IDLE.
- `rsp_ready` already high when `rsp_valid` rises gives a response handshake in that same cycle. IDLE follows next cycle, so the next command can be accepted at T+3.
- `reset_L` asserted mid-transaction forces all reset values immediately. The in-flight response is lost, and `req` falls asynchronously.
- All outputs are registered except `cmd_ready` and `busy`, which are decoded from the state register.

## Configuration

- Macro: `REGS_MASTER_TIMEOUT_EN`.
- Defined:
  - If the wait counter reaches `TIMEOUT_P - 1` in REQ with `ack` = 0, the FSM goes to RSP.
  - In that case `rsp_err` = 1 and `rsp_rdata` = 0, and `req` drops on the next cycle.
  - If `ack` arrives in the same cycle the limit is reached, `ack` wins: normal response with `rsp_err` = 0.
- Undefined:
  - No counter logic. REQ waits indefinitely for `ack`.
  - `rsp_err` is tied to 0.

## Test plan

- Write: cmd write, addr 0x3, wdata 0x0000_0005; `ack` 2 cycles after `req` rises. Expect `req` high for 3 cycles with `addr` = 3, `rd_wr` = 1, `write_val` = 5. Expect `rsp_valid` with `rsp_rdata` = 0 and `rsp_err` = 0.
- Read: cmd read, addr 0x1; `ack` in the first `req` cycle with `read_val` = 0xA5A5_0003. Expect `rsp_valid` at T+2 with `rsp_rdata` = 0xA5A5_0003.
- Response backpressure: hold `rsp_ready` = 0 for 5 cycles with `cmd_valid` held high. Expect `cmd_ready` = 0, no new `req`, and stable `rsp_rdata` throughout. After `rsp_ready` = 1, expect the next command to be accepted one cycle later.
- Spurious ack: pulse `ack` while in IDLE and while in RSP. Expect no state change and no extra `rsp_valid`.
- Timeout (macro defined, `TIMEOUT_P` = 16): never ack. Expect `req` high for exactly 16 cycles, then `rsp_err` = 1 and `rsp_rdata` = 0. Repeat with `ack` on the 16th `req` cycle: expect `rsp_err` = 0.
- Reset mid-REQ: assert `reset_L` = 0 while `req` = 1. Expect `req` = 0, `busy` = 0 and `cmd_ready` = 1 immediately. After release, a new read completes normally.

Source files
------------

// File: rtl/regs_master.sv
// regs_master: register-bus initiator. Accepts one host command at a time over
// a valid/ready port, drives a single req/ack register transaction, and returns
// the result over a valid/ready response port.
// Optional feature macro: REGS_MASTER_TIMEOUT_EN (ack timeout with error response).
module regs_master #(
  parameter int ADDR_SIZE_P = 4,
  parameter int TIMEOUT_P   = 16
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_rd_wr,
  input  logic [ADDR_SIZE_P-1:0] cmd_addr,
  input  logic [31:0]            cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic                   req,
  output logic [ADDR_SIZE_P-1:0] addr,
  output logic                   rd_wr,
  output logic [31:0]            write_val,
  input  logic [31:0]            read_val,
  input  logic                   ack,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2} state_t;

  state_t state;
  state_t state_nxt;
  logic   timeout_hit;

  // TIMEOUT_P is only meaningful in 2..255; an out-of-range value leaves a
  // visible marker scope in the elaborated hierarchy.
  if (TIMEOUT_P < 2 || TIMEOUT_P > 255) begin : g_timeout_p_out_of_range
  end

`ifdef REGS_MASTER_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // Wait counter: zero outside REQ, so it is cleared on every entry to REQ.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)          wait_cnt <= 8'd0;
    else if (state != REQ) wait_cnt <= 8'd0;
    else                   wait_cnt <= wait_cnt + 8'd1;
  end

  // A same-cycle ack takes priority over the timeout.
  assign timeout_hit = (state == REQ) && !ack && (wait_cnt == 8'(TIMEOUT_P - 1));

  // Error flag: set on timeout, cleared on a real ack, held through RSP.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rsp_err <= 1'b0;
    end else if (state == REQ) begin
      if (ack)              rsp_err <= 1'b0;
      else if (timeout_hit) rsp_err <= 1'b1;
    end
  end
`else
  // Without the timeout feature REQ waits for ack indefinitely.
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode; ack outside REQ is deliberately ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid)          state_nxt = REQ;
      REQ:     if (ack || timeout_hit) state_nxt = RSP;
      RSP:     if (rsp_ready)          state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Host-side handshake outputs decoded straight from the state register.
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
  end

  // Registered bus/response outputs; bus fields persist after completion.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      req       <= 1'b0;
      rsp_valid <= 1'b0;
      addr      <= '0;
      rd_wr     <= 1'b0;
      write_val <= 32'd0;
      rsp_rdata <= 32'd0;
    end else begin
      req       <= (state_nxt == REQ);
      rsp_valid <= (state_nxt == RSP);
      if (state == IDLE && cmd_valid) begin
        addr      <= cmd_addr;
        rd_wr     <= cmd_rd_wr;
        write_val <= cmd_wdata;
      end
      if (state == REQ) begin
        if (ack)              rsp_rdata <= rd_wr ? 32'd0 : read_val;
        else if (timeout_hit) rsp_rdata <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_regs_master.sv
// Directed self-checking bench for regs_master.
module tb_regs_master;

  logic        clk;
  logic        reset_L;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rd_wr;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        req;
  logic [3:0]  addr;
  logic        rd_wr;
  logic [31:0] write_val;
  logic [31:0] read_val;
  logic        ack;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  regs_master #(.ADDR_SIZE_P(4), .TIMEOUT_P(16)) dut (
    .clk(clk), .reset_L(reset_L),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd_wr(cmd_rd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .req(req), .addr(addr), .rd_wr(rd_wr), .write_val(write_val),
    .read_val(read_val), .ack(ack), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global guard so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic rw, input logic [3:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_rd_wr = rw;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  initial begin
    int cnt;
    reset_L   = 1'b0;
    cmd_valid = 1'b0;
    cmd_rd_wr = 1'b0;
    cmd_addr  = 4'h0;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b1;
    read_val  = 32'h0;
    ack       = 1'b0;
    #1;
    // ---------------- reset values
    chk("rst_req", req, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_addr", addr, 0);
    chk("rst_rd_wr", rd_wr, 0);
    chk("rst_write_val", write_val, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    tick();
    tick();
    reset_L = 1'b1;
    tick();

    // ---------------- write, ack 2 cycles after req rises
    send(1'b1, 4'h3, 32'h0000_0005);
    tick();
    cmd_valid = 1'b0;
    chk("wr_req_c1", req, 1);
    chk("wr_addr", addr, 4'h3);
    chk("wr_rd_wr", rd_wr, 1);
    chk("wr_write_val", write_val, 32'h5);
    chk("wr_cmd_ready", cmd_ready, 0);
    chk("wr_busy", busy, 1);
    tick();
    chk("wr_req_c2", req, 1);
    tick();
    chk("wr_req_c3", req, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("wr_req_drop", req, 0);
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_rsp_err", rsp_err, 0);
    tick();
    chk("wr_idle_rsp_valid", rsp_valid, 0);
    chk("wr_idle_cmd_ready", cmd_ready, 1);
    chk("wr_addr_kept", addr, 4'h3);

    // ---------------- read, ack in first req cycle
    send(1'b0, 4'h1, 32'hDEAD_BEEF);
    tick();
    cmd_valid = 1'b0;
    chk("rd_req", req, 1);
    chk("rd_addr", addr, 4'h1);
    chk("rd_rd_wr", rd_wr, 0);
    ack = 1'b1;
    read_val = 32'hA5A5_0003;
    tick();
    ack = 1'b0;
    read_val = 32'h0;
    chk("rd_rsp_valid_t2", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 32'hA5A5_0003);
    chk("rd_req_drop", req, 0);
    tick();
    chk("rd_idle", busy, 0);

    // ---------------- response backpressure with cmd_valid held high
    rsp_ready = 1'b0;
    send(1'b0, 4'h2, 32'h0);
    tick();
    chk("bp_req", req, 1);
    ack = 1'b1;
    read_val = 32'h1234_5678;
    send(1'b1, 4'h7, 32'h0000_0077);
    tick();
    ack = 1'b0;
    read_val = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_no_req", req, 0);
      chk("bp_rdata_stable", rsp_rdata, 32'h1234_5678);
      tick();
    end
    rsp_ready = 1'b1;
    chk("bp_rsp_valid_hs", rsp_valid, 1);
    tick();
    chk("bp_idle_cmd_ready", cmd_ready, 1);
    chk("bp_idle_rsp_valid", rsp_valid, 0);
    tick();
    cmd_valid = 1'b0;
    chk("bp_next_req", req, 1);
    chk("bp_next_addr", addr, 4'h7);
    chk("bp_next_rd_wr", rd_wr, 1);
    chk("bp_next_wval", write_val, 32'h77);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("bp_next_rdata", rsp_rdata, 0);
    chk("bp_next_rsp_valid", rsp_valid, 1);
    tick();

    // ---------------- spurious ack in IDLE and in RSP
    ack = 1'b1;
    read_val = 32'h5555_5555;
    tick();
    ack = 1'b0;
    chk("sp_idle_busy", busy, 0);
    chk("sp_idle_req", req, 0);
    chk("sp_idle_rsp_valid", rsp_valid, 0);
    chk("sp_idle_cmd_ready", cmd_ready, 1);
    rsp_ready = 1'b0;
    send(1'b0, 4'h9, 32'h0);
    tick();
    cmd_valid = 1'b0;
    ack = 1'b1;
    read_val = 32'h0BAD_F00D;
    tick();
    chk("sp_rsp_valid", rsp_valid, 1);
    read_val = 32'h1111_1111;
    tick();
    ack = 1'b0;
    chk("sp_rsp_hold_valid", rsp_valid, 1);
    chk("sp_rsp_hold_rdata", rsp_rdata, 32'h0BAD_F00D);
    chk("sp_rsp_hold_err", rsp_err, 0);
    chk("sp_rsp_no_req", req, 0);
    rsp_ready = 1'b1;
    tick();
    chk("sp_after_rsp_valid", rsp_valid, 0);
    tick();
    chk("sp_no_extra_rsp", rsp_valid, 0);
    chk("sp_no_extra_busy", busy, 0);

`ifdef REGS_MASTER_TIMEOUT_EN
    // ---------------- timeout: never ack
    read_val = 32'hCAFE_0000;
    send(1'b0, 4'h4, 32'h0);
    tick();
    cmd_valid = 1'b0;
    cnt = 0;
    while (req === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("to_req_cycles", cnt, 16);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    tick();
    chk("to_idle", busy, 0);

    // ---------------- ack on the 16th req cycle wins over timeout
    send(1'b0, 4'h4, 32'h0);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("to_ack_req16", req, 1);
    ack = 1'b1;
    read_val = 32'hCAFE_0016;
    tick();
    ack = 1'b0;
    chk("to_ack_rsp_valid", rsp_valid, 1);
    chk("to_ack_rsp_err", rsp_err, 0);
    chk("to_ack_rdata", rsp_rdata, 32'hCAFE_0016);
    tick();
`else
    // ---------------- no timeout: REQ waits indefinitely for ack
    send(1'b0, 4'h4, 32'h0);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("nto_req_held", req, 1);
    chk("nto_no_rsp", rsp_valid, 0);
    ack = 1'b1;
    read_val = 32'hCAFE_0021;
    tick();
    ack = 1'b0;
    chk("nto_rsp_valid", rsp_valid, 1);
    chk("nto_rsp_err", rsp_err, 0);
    chk("nto_rdata", rsp_rdata, 32'hCAFE_0021);
    tick();
`endif

    // ---------------- asynchronous reset in the middle of REQ
    send(1'b0, 4'h5, 32'h0);
    tick();
    cmd_valid = 1'b0;
    chk("mr_req_before", req, 1);
    #2;
    reset_L = 1'b0;
    #1;
    chk("mr_req", req, 0);
    chk("mr_busy", busy, 0);
    chk("mr_cmd_ready", cmd_ready, 1);
    chk("mr_addr", addr, 0);
    chk("mr_rsp_valid", rsp_valid, 0);
    tick();
    reset_L = 1'b1;
    tick();
    send(1'b0, 4'h6, 32'h0);
    tick();
    cmd_valid = 1'b0;
    chk("mr_new_req", req, 1);
    chk("mr_new_addr", addr, 4'h6);
    ack = 1'b1;
    read_val = 32'h600D_0006;
    tick();
    ack = 1'b0;
    chk("mr_new_rsp_valid", rsp_valid, 1);
    chk("mr_new_rdata", rsp_rdata, 32'h600D_0006);
    chk("mr_new_err", rsp_err, 0);
    tick();
    chk("mr_new_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
